// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
// Holds width defaults, the return-state encoding and byte-enable constants.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 32;

    localparam logic [3:0] BE_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        RET_I,
        RET_D
    } ret_state_e;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of consecutive data grants taken while fetch waits.
// Ports: clk, rst (sync, active-high), inc, clr in; at_limit out.
module starve_counter #(
    parameter int LIMIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam int CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_limit = (cnt == MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-cycle memory port.
// Ports: i_* fetch request/return, d_* data request/return, mem_* memory side.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_stall,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [DATA_W-1:0] mem_rdata
);

    ret_state_e state;
    ret_state_e state_nxt;

    logic starved;
    logic i_pick;
    logic d_pick;

    // Data wins contention unless fetch has waited the full limit.
    assign i_pick = i_req & (~d_req | starved);
    assign d_pick = d_req & ~i_pick;

    // Reset forces every output quiet whatever the requests are doing.
    assign i_gnt   = ~rst & i_pick;
    assign d_gnt   = ~rst & d_pick;
    assign i_stall = ~rst & i_req & ~i_gnt;

    starve_counter #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc      (d_gnt & i_req),
        .clr      (i_gnt | ~i_req),
        .at_limit (starved)
    );

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        unique case (1'b1)
            i_gnt: begin
                mem_en   = 1'b1;
                mem_addr = i_addr;
                mem_be   = BE_ALL;
            end
            d_gnt: begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_be    = d_be;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The state register still holds a stale return during the first
    // reset cycle, so the return outputs are gated by rst as well.
    always_comb begin
        state_nxt = IDLE;
        i_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rvalid  = 1'b0;
        d_rdata   = '0;
        if (i_gnt) begin
            state_nxt = RET_I;
        end else if (d_gnt && !d_we) begin
            state_nxt = RET_D;
        end
        if (!rst) begin
            unique case (state)
                RET_I: begin
                    i_rvalid = 1'b1;
                    i_rdata  = mem_rdata;
                end
                RET_D: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter with a memory model.
// Expected grants and returns come from a reference model and a queue.
module tb_mem_port_arbiter;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int LIM = 3;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } ret_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_stall;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_be;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_stall   (i_stall),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_be      (d_be),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem     [64];
    logic [DW-1:0] ref_mem [64];
    ret_t          q [$];
    int            m_cnt;
    int            total;
    int            bad;
    logic          last_i;
    logic          last_ei;
    logic          last_ed;
    logic [DW-1:0] last_ird;
    logic [4:0]    pat;

    task automatic chk(input string tag, input logic [79:0] obs,
                       input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic          hit;
        logic          ei;
        logic          ed;
        logic [79:0]   em;
        logic [79:0]   er;
        ret_t          r;
        logic          c_en;
        logic          c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic [3:0]    c_be;
        @(negedge clk);
        hit = i_req && (!d_req || (m_cnt == LIM));
        ei  = !rst && hit;
        ed  = !rst && d_req && !hit;
        chk("i_gnt", 80'(i_gnt), 80'(ei));
        chk("d_gnt", 80'(d_gnt), 80'(ed));
        chk("i_stall", 80'(i_stall), 80'(!rst && i_req && !ei));
        em = '0;
        if (ei) em = {1'b1, 1'b0, i_addr, 4'hF, 32'h0};
        else if (ed) em = {1'b1, d_we, d_addr, d_be, d_wdata};
        chk("mem_port", {mem_en, mem_we, mem_addr, mem_be, mem_wdata}, em);
        er = '0;
        if (rst) begin
            q.delete();
        end else if (q.size() > 0) begin
            r  = q.pop_front();
            er = r.port ? {1'b0, 32'h0, 1'b1, r.data}
                        : {1'b1, r.data, 1'b0, 32'h0};
        end
        chk("return", {i_rvalid, i_rdata, d_rvalid, d_rdata}, er);
        if (ei) q.push_back('{1'b0, ref_mem[i_addr]});
        if (ed && !d_we) q.push_back('{1'b1, ref_mem[d_addr]});
        if (ed && d_we) begin
            for (int b = 0; b < 4; b++)
                if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
        end
        if (rst || ei || !i_req) m_cnt = 0;
        else if (ed && m_cnt < LIM) m_cnt++;
        last_i   = i_gnt;
        last_ei  = ei;
        last_ed  = ed;
        last_ird = i_rdata;
        c_en     = mem_en;
        c_we     = mem_we;
        c_addr   = mem_addr;
        c_wdata  = mem_wdata;
        c_be     = mem_be;
        @(posedge clk);
        if (c_en && c_we) begin
            for (int b = 0; b < 4; b++)
                if (c_be[b]) mem[c_addr][8*b +: 8] = c_wdata[8*b +: 8];
        end
        if (c_en && !c_we) mem_rdata = mem[c_addr];
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        m_cnt     = 0;
        mem_rdata = '0;
        pat       = '0;
        for (int k = 0; k < 64; k++) begin
            mem[k]     = 32'hA5000000 | k;
            ref_mem[k] = 32'hA5000000 | k;
        end
        mem[2] = 32'h01DFF463; ref_mem[2] = 32'h01DFF463;
        mem[3] = 32'h11223344; ref_mem[3] = 32'h11223344;
        mem[5] = 32'hCAFE0005; ref_mem[5] = 32'hCAFE0005;

        // reset with both requesters active
        rst = 1'b1; i_req = 1'b1; i_addr = 6'd1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd4;
        d_wdata = '0; d_be = 4'hF;
        cycle();
        cycle();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
        cycle();

        // lone fetch of word 2, then return
        i_req = 1'b1; i_addr = 6'd2;
        cycle();
        i_req = 1'b0;
        cycle();
        chk("fetch_w2", 80'(last_ird), 80'(32'h01DFF463));

        // contention: data read of word 5 wins
        i_req = 1'b1; i_addr = 6'd7;
        d_req = 1'b1; d_we = 1'b0; d_addr = 6'd5;
        cycle();
        i_req = 1'b0; d_req = 1'b0;
        cycle();
        cycle();

        // starvation: five held cycles
        i_req = 1'b1; i_addr = 6'd9;
        d_req = 1'b1; d_addr = 6'd10;
        for (int c = 0; c < 5; c++) begin
            cycle();
            pat = {pat[3:0], last_i};
        end
        chk("starve_pat", 80'(pat), 80'(5'b00010));
        i_req = 1'b0; d_req = 1'b0;
        cycle();

        // partial write, then fetch it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 6'd3;
        d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        cycle();
        d_req = 1'b0; d_we = 1'b0;
        cycle();
        i_req = 1'b1; i_addr = 6'd3;
        cycle();
        i_req = 1'b0;
        cycle();
        chk("write_rb", 80'(last_ird), 80'(32'h1122BEEF));

        // reset hits a pending fetch return
        i_req = 1'b1; i_addr = 6'd2;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; i_req = 1'b0;
        cycle();
        cycle();

        // random traffic, stalled requesters keep their fields
        last_ei = 1'b0;
        last_ed = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!i_req || last_ei) begin
                i_req  = 1'($urandom_range(0, 1));
                i_addr = AW'($urandom_range(0, 63));
            end
            if (!d_req || last_ed) begin
                d_req   = 1'($urandom_range(0, 1));
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = AW'($urandom_range(0, 63));
                d_wdata = $urandom;
                d_be    = 4'($urandom_range(0, 15));
            end
            cycle();
        end
        i_req = 1'b0; d_req = 1'b0;
        cycle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 6, word address width (64-word memory).
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter STARVE_LIMIT, default 3, max consecutive data grants while fetch waits.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 i_req  in  1  fetch request; i_addr  in  ADDR_W  fetch word address.
REQ-007 i_gnt  out  1  fetch granted this cycle; i_stall  out  1  = i_req & ~i_gnt.
REQ-008 i_rvalid  out  1 and i_rdata  out  DATA_W  fetch read return.
REQ-009 d_req  in  1; d_we  in  1; d_addr  in  ADDR_W; d_wdata  in  DATA_W; d_be  in  4  byte enables for data access.
REQ-010 d_gnt  out  1; d_rvalid  out  1; d_rdata  out  DATA_W  data-port grant and read return.
REQ-011 mem_en, mem_we  out  1; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  4  single memory port.
REQ-012 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en & ~mem_we.

Function
REQ-013 At most one of i_gnt, d_gnt SHALL be high per cycle; grant is combinational from current requests and state.
REQ-014 Only one requester active: that requester SHALL be granted in the same cycle.
REQ-015 Both active: d_gnt SHALL win unless starve_cnt == STARVE_LIMIT, then i_gnt wins.
REQ-016 starve_cnt SHALL increment on each cycle with d_gnt & i_req, clear on any i_gnt or when i_req low, saturate at STARVE_LIMIT.
REQ-017 On a grant, mem_en SHALL be 1 and mem_addr/mem_we/mem_wdata/mem_be SHALL carry the granted port's fields; fetch drives mem_we=0, mem_be=4'hF.
REQ-018 No grant: mem_en=0, mem_we=0, other mem_* outputs 0.
REQ-019 Return FSM states: IDLE, RET_I, RET_D; next state RET_I after fetch grant, RET_D after data read grant, IDLE otherwise (including data writes).
REQ-020 In RET_I, i_rvalid=1 and i_rdata=mem_rdata; in RET_D, d_rvalid=1 and d_rdata=mem_rdata; rdata outputs 0 when not valid.
REQ-021 Read latency SHALL be exactly 1 cycle from grant to rvalid; back-to-back grants SHALL sustain one access per cycle.
REQ-022 Data writes SHALL produce no rvalid.
REQ-023 Requests are level: an ungranted requester SHALL hold its fields stable; arbiter holds no request state beyond starve_cnt.

Reset
REQ-024 While rst=1: FSM=IDLE, starve_cnt=0, all grant, rvalid, rdata and mem_* outputs 0, regardless of requests.
REQ-025 Reset mid-access SHALL drop any pending return; no rvalid in the cycle after rst deasserts.

Structure
REQ-026 Shared package holds ADDR_W/DATA_W defaults, return-state enum (IDLE, RET_I, RET_D) and byte-enable constant BE_ALL=4'hF.
REQ-027 Sub-module starve_counter (saturating counter with inc/clr) is natural; rest is flat.

Verification
REQ-028 i_req=1, i_addr=2, d_req=0, mem word2=32'h01DFF463 -> i_gnt same cycle, next cycle i_rvalid=1, i_rdata=32'h01DFF463.
REQ-029 i_req=1 and d_req=1 (read, addr 5) same cycle -> d_gnt=1, i_stall=1; next cycle d_rvalid=1, word5 returned.
REQ-030 i_req held, d_req held 5 cycles, STARVE_LIMIT=3 -> d_gnt cycles 0-2, i_gnt cycle 3, d_gnt cycle 4.
REQ-031 d_we=1, d_addr=3, d_wdata=32'hDEADBEEF, d_be=4'b0011 -> mem_we=1, mem_be=4'b0011; no d_rvalid; later fetch of addr 3 returns written bytes.
REQ-032 Fetch granted, rst=1 next cycle -> i_rvalid=0, all outputs 0; after rst release with no request, outputs remain 0.
REQ-033 Random req traffic 1000 cycles -> never both grants, every read grant matched by exactly one rvalid 1 cycle later.
